// File: rtl/qspi_read_ctrl.sv
// Quad Output Fast Read (0x6B) sequencer for the SoC QSPI flash port.
// Turns burst-read requests into CS/SCLK/IO activity and a 32-bit word stream.
module qspi_read_ctrl #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned DUMMY_CYCLES   = 8,
    parameter int unsigned CS_HIGH_CYCLES = 4,
    parameter int unsigned LEN_W          = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [23:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_last_o,
    output logic             busy_o,
    output logic             qspi_sclk_o,
    output logic             qspi_cs_no,
    output logic [3:0]       qspi_data_o,
    input  logic [3:0]       qspi_data_i,
    output logic [3:0]       qspi_data_oen
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        CS_HOLD
    } state_t;

    localparam logic [7:0] CMD_QOR   = 8'h6B;
    localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
    localparam logic [5:0] DUMMY_END = 6'(DUMMY_CYCLES - 1);
    localparam int unsigned HOLD_W   = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(CS_HIGH_CYCLES - 1);

    state_t             state_q;
    logic [7:0]         div_q;
    logic [5:0]         bit_q;
    logic [LEN_W-1:0]   words_q;
    logic [31:0]        tx_q;
    logic [31:0]        rx_q;
    logic               pend_q;
    logic               pend_last_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               sclk_q;
    logic               cs_n_q;
    logic [3:0]         dout_q;
    logic [3:0]         oen_q;
    logic               rsp_valid_q;
    logic               rsp_last_q;
    logic [31:0]        rsp_data_q;

    logic div_end;
    logic stall;

    assign div_end = (div_q == DIV_END);
    // A new word may not start while the previous one is still unconsumed.
    assign stall = (state_q == DATA) && !sclk_q && (bit_q == 6'd0)
                && rsp_valid_q && !rsp_ready_i;

    assign req_ready_o   = (state_q == IDLE) && !rsp_valid_q;
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_last_o    = rsp_last_q;
    assign rsp_data_o    = rsp_data_q;
    assign qspi_sclk_o   = sclk_q;
    assign qspi_cs_no    = cs_n_q;
    assign qspi_data_o   = dout_q;
    assign qspi_data_oen = oen_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            words_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            hold_q      <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            dout_q      <= 4'b0000;
            oen_q       <= 4'b1111;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                rsp_last_q  <= 1'b0;
            end
            if (pend_q) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_q;
                rsp_last_q  <= pend_last_q;
                pend_q      <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o && (req_len_i != '0)) begin
                        state_q <= CS_SETUP;
                        words_q <= req_len_i;
                        tx_q    <= {CMD_QOR, req_addr_i};
                        div_q   <= '0;
                        cs_n_q  <= 1'b0;
                        dout_q  <= {2'b11, 1'b0, CMD_QOR[7]};
                        oen_q   <= 4'b0010;
                    end
                end
                CS_SETUP: begin
                    if (div_end) begin
                        sclk_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= CMD;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (!div_end) begin
                        div_q <= div_q + 8'd1;
                    end else if (!sclk_q) begin
                        if (!stall) begin
                            sclk_q <= 1'b1;
                            div_q  <= '0;
                            if (state_q == DATA) begin
                                // first nibble of each byte is its high half
                                rx_q[{bit_q[2:1], ~bit_q[0], 2'b00} +: 4] <= qspi_data_i;
                                if (bit_q[2:0] == 3'd7) begin
                                    pend_q      <= 1'b1;
                                    pend_last_q <= (words_q == LEN_W'(1));
                                    words_q     <= words_q - LEN_W'(1);
                                end
                            end
                        end
                    end else begin
                        sclk_q <= 1'b0;
                        div_q  <= '0;
                        unique case (state_q)
                            CMD, ADDR: begin
                                tx_q      <= tx_q << 1;
                                dout_q[0] <= tx_q[30];
                                bit_q     <= bit_q + 6'd1;
                                if (bit_q == 6'd7) begin
                                    state_q <= ADDR;
                                end
                                if (bit_q == 6'd31) begin
                                    state_q <= DUMMY;
                                    bit_q   <= '0;
                                    dout_q  <= 4'b0000;
                                    oen_q   <= 4'b1111;
                                end
                            end
                            DUMMY: begin
                                if (bit_q == DUMMY_END) begin
                                    state_q <= DATA;
                                    bit_q   <= '0;
                                end else begin
                                    bit_q <= bit_q + 6'd1;
                                end
                            end
                            DATA: begin
                                if (bit_q[2:0] == 3'd7) begin
                                    bit_q <= '0;
                                    if (words_q == '0) begin
                                        state_q <= CS_HOLD;
                                        hold_q  <= '0;
                                    end
                                end else begin
                                    bit_q <= bit_q + 6'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CS_HOLD: begin
                    cs_n_q <= 1'b1;
                    if (cs_n_q) begin
                        if (hold_q == HOLD_END) begin
                            state_q <= IDLE;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
